// File: rtl/serial_adder_if.sv
// Handshake and operand bundle for serial_adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop add two WIDTH-bit
// operands LSB-first, one bit per clock, with a start/busy/done handshake and
// signed-overflow reporting.
// Optional feature: SERIAL_ADDER_SUB_EN adds a sub input that turns the
// operation into a-b (B inverted, carry-in forced to 1).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; operands are latched on the accepting edge
// RUN    | one operand bit pair consumed per cycle, LSB first
// DONE   | one-cycle done pulse; results already registered, back to IDLE
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Full-adder cell on the current LSBs and the carry flop.
  always_comb begin
    s_bit  = sh_a[0] ^ sh_b[0] ^ carry;
    c_next = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
  end

  // Result shift register input: new sum bit enters at the MSB.
  always_comb begin
    res_next            = sh_r >> 1;
    res_next[WIDTH-1]   = s_bit;
  end

  // Operand B and carry-in as loaded on start; subtraction uses a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load = bus.sub ? ~bus.b : bus.b;
    c_load = bus.sub ? 1'b1   : bus.cin;
  end
`else
  always_comb begin
    b_load = bus.b;
    c_load = bus.cin;
  end
`endif

  // Sequencer and datapath registers; results update only on RUN->DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      sh_r   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sh_a  <= bus.a;
            sh_b  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          sh_r  <= res_next;
          carry <= c_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB on this cycle
            sum_q  <= res_next;
            cout_q <= c_next;
            ovf_q  <= carry ^ c_next;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
